// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Definitions shared by the fetch queue and the x86-64 instruction decoder.
//   MAX_INST_BYTES : longest legal x86-64 instruction, and the window width
//   FILL_BYTES     : bytes delivered per Sysbus fill beat
//   inst_field_t   : instruction field classes, shared by fetch and decode
//   byte_window_t  : decoder window, byte i at [i*8 +: 8], byte 0 first
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int MAX_INST_BYTES = 15;
    localparam int FILL_BYTES     = 8;

    typedef enum logic [2:0] {
        FIELD_PREFIX = 3'd0,
        FIELD_REX    = 3'd1,
        FIELD_OPCODE = 3'd2,
        FIELD_MODRM  = 3'd3,
        FIELD_SIB    = 3'd4,
        FIELD_DISP   = 3'd5,
        FIELD_IMM    = 3'd6
    } inst_field_t;

    typedef logic [0:MAX_INST_BYTES*8-1] byte_window_t;

endpackage

// File: rtl/fq_byte_align.sv
// -----------------------------------------------------------------------------
// fq_byte_align
// Combinational next-state builder for the fetch queue byte array.
// The queue is held flat with byte k at [8k +: 8] (byte 0 is the head).
//   i_q     : current queue contents
//   i_shift : bytes retired from the head this cycle (0..15)
//   i_fill  : a beat is appended this cycle
//   i_beat  : 64-bit beat, memory byte k at [8k +: 8]
//   i_skip  : leading beat bytes to discard (misaligned redirect target)
//   i_pos   : queue byte index where the first kept beat byte lands
//   o_q     : queue contents after shift and merge
// -----------------------------------------------------------------------------
module fq_byte_align
    import decoder_pkg::*;
#(
    parameter int  QUEUE_BYTES = 32,
    localparam int CW          = $clog2(QUEUE_BYTES + 1)
) (
    input  logic [QUEUE_BYTES*8-1:0] i_q,
    input  logic [3:0]               i_shift,
    input  logic                     i_fill,
    input  logic [63:0]              i_beat,
    input  logic [2:0]               i_skip,
    input  logic [CW-1:0]            i_pos,
    output logic [QUEUE_BYTES*8-1:0] o_q
);

    // Beat with the skipped leading bytes removed; kept byte r sits at [8r +: 8].
    logic [63:0] w_beat;
    assign w_beat = i_beat >> {i_skip, 3'b000};

    always_comb begin
        logic [2:0] rel;
        rel = '0;
        // Shifting right moves higher-indexed bytes toward the head; zeros enter at the tail.
        o_q = i_q >> {i_shift, 3'b000};
        if (i_fill) begin
            for (int j = 0; j < QUEUE_BYTES; j++) begin
                if ((j >= int'(i_pos)) &&
                    (j < int'(i_pos) + FILL_BYTES - int'(i_skip))) begin
                    rel = 3'(j - int'(i_pos));
                    o_q[j*8 +: 8] = w_beat[{rel, 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-byte queue between the 64-bit Sysbus fill path and the x86-64
// decoder. Aligned 8-byte beats are appended at the tail; the decoder sees the
// first 15 bytes as a window and retires 1..15 bytes per consume.
// Optional trace: define FETCH_QUEUE_TRACE_EN to print fills, consumes and
// redirects during simulation (no functional effect).
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   redirect, redirect_pc   : flush and restart fetch at any byte address
//   fetch_addr              : aligned address of the next beat to fetch
//   fill_valid/ready/data   : beat handshake (beat moves when valid & ready)
//   buffer, buf_valid       : 15-byte window, valid when 15+ bytes queued
//   consume, byte_incr      : decoder retires byte_incr bytes
//   decode_pc               : PC of window byte 0
//   occupancy               : queued byte count
//   err                     : sticky flag for an illegal consume
// Handshakes: a beat transfers on a clock edge where fill_valid and
// fill_ready are both high; fill_ready depends only on registered state, so
// the source must hold the beat (and its data) until it sees ready.
// -----------------------------------------------------------------------------
module fetch_queue
    import decoder_pkg::*;
#(
    parameter int          QUEUE_BYTES = 32,
    parameter logic [63:0] RESET_PC    = 64'h0,
    localparam int         CW          = $clog2(QUEUE_BYTES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect,
    input  logic [63:0]   redirect_pc,
    output logic [63:0]   fetch_addr,
    input  logic          fill_valid,
    output logic          fill_ready,
    input  logic [63:0]   fill_data,
    output byte_window_t  buffer,
    output logic          buf_valid,
    input  logic          consume,
    input  logic [3:0]    byte_incr,
    output logic [63:0]   decode_pc,
    output logic [CW-1:0] occupancy,
    output logic          err
);

    logic [QUEUE_BYTES*8-1:0] r_q;
    logic [CW-1:0]            r_count;
    logic [2:0]               r_skip;
    logic [63:0]              r_fetch_addr;
    logic [63:0]              r_decode_pc;
    logic                     r_err;

    logic                     w_fill_ok;
    logic                     w_cons_ok;
    logic                     w_cons_bad;
    logic [3:0]               w_cons_amt;
    logic [3:0]               w_fill_amt;
    logic [CW-1:0]            w_pos;
    logic [CW-1:0]            w_count_next;
    logic [QUEUE_BYTES*8-1:0] w_q_next;

    assign fill_ready = (r_count <= CW'(QUEUE_BYTES - FILL_BYTES));
    assign buf_valid  = (r_count >= CW'(MAX_INST_BYTES));

    assign w_fill_ok  = fill_valid & fill_ready;
    assign w_cons_ok  = consume & buf_valid & (byte_incr != 4'd0);
    assign w_cons_bad = consume & ~w_cons_ok;
    assign w_cons_amt = w_cons_ok ? byte_incr : 4'd0;
    assign w_fill_amt = 4'(FILL_BYTES) - {1'b0, r_skip};

    // The beat lands right after whatever survives this cycle's consume.
    assign w_pos        = r_count - CW'(w_cons_amt);
    assign w_count_next = w_pos + (w_fill_ok ? CW'(w_fill_amt) : '0);

    fq_byte_align #(
        .QUEUE_BYTES(QUEUE_BYTES)
    ) u_align (
        .i_q    (r_q),
        .i_shift(w_cons_amt),
        .i_fill (w_fill_ok),
        .i_beat (fill_data),
        .i_skip (r_skip),
        .i_pos  (w_pos),
        .o_q    (w_q_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= '0;
            r_count      <= '0;
            r_skip       <= RESET_PC[2:0];
            r_fetch_addr <= {RESET_PC[63:3], 3'b000};
            r_decode_pc  <= RESET_PC;
            r_err        <= 1'b0;
        end else if (redirect) begin
            // Same-cycle fill and consume are dropped; queue bytes become don't-care.
            r_count      <= '0;
            r_skip       <= redirect_pc[2:0];
            r_fetch_addr <= {redirect_pc[63:3], 3'b000};
            r_decode_pc  <= redirect_pc;
        end else begin
            r_q     <= w_q_next;
            r_count <= w_count_next;
            if (w_fill_ok) begin
                r_skip       <= 3'd0;
                r_fetch_addr <= r_fetch_addr + 64'd8;
            end
            if (w_cons_ok) begin
                r_decode_pc <= r_decode_pc + 64'(w_cons_amt);
            end
            if (w_cons_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        buffer = '0;
        for (int i = 0; i < MAX_INST_BYTES; i++) begin
            buffer[i*8 +: 8] = r_q[i*8 +: 8];
        end
    end

    assign fetch_addr = r_fetch_addr;
    assign decode_pc  = r_decode_pc;
    assign occupancy  = r_count;
    assign err        = r_err;

`ifdef FETCH_QUEUE_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (redirect) begin
                $display("fetch_queue: redirect to %016h", redirect_pc);
            end else begin
                if (w_fill_ok) begin
                    $display("fetch_queue: fill addr %016h data %016h", r_fetch_addr, fill_data);
                end
                if (w_cons_ok) begin
                    $display("fetch_queue: consume pc %016h bytes %0d", r_decode_pc, byte_incr);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          QB       = 32;
    localparam int          CW       = $clog2(QB + 1);
    localparam logic [63:0] RESET_PC = 64'h0;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic [63:0]   fetch_addr;
    logic          fill_valid;
    logic          fill_ready;
    logic [63:0]   fill_data;
    logic [0:119]  buffer;
    logic          buf_valid;
    logic          consume;
    logic [3:0]    byte_incr;
    logic [63:0]   decode_pc;
    logic [CW-1:0] occupancy;
    logic          err;

    always #5 clk = ~clk;

    fetch_queue #(
        .QUEUE_BYTES(QB),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_addr (fetch_addr),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_data  (fill_data),
        .buffer     (buffer),
        .buf_valid  (buf_valid),
        .consume    (consume),
        .byte_incr  (byte_incr),
        .decode_pc  (decode_pc),
        .occupancy  (occupancy),
        .err        (err)
    );

    // ---------------- reference model (scoreboard) ----------------
    logic [7:0]  exp_q[$];   // queued bytes, head first
    logic [2:0]  m_skip;
    logic [63:0] m_faddr;
    logic [63:0] m_dpc;
    logic        m_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Synthetic memory image; addresses below 0x100 read back their own low byte.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[63:56];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_skip  = RESET_PC[2:0];
        m_faddr = {RESET_PC[63:3], 3'b000};
        m_dpc   = RESET_PC;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic rd, input logic [63:0] rpc, input logic fv,
                              input logic cs, input logic [3:0] inc);
        int  n;
        logic cok;
        if (rd) begin
            exp_q.delete();
            m_skip  = rpc[2:0];
            m_faddr = {rpc[63:3], 3'b000};
            m_dpc   = rpc;
        end else begin
            n   = exp_q.size();
            cok = cs && (n >= 15) && (inc != 4'd0);
            if (cs && !cok) m_err = 1'b1;
            if (cok) begin
                for (int k = 0; k < int'(inc); k++) exp_q.delete(0);
                m_dpc = m_dpc + 64'(inc);
            end
            // Fill acceptance is decided on the count before this cycle's consume.
            if (fv && (n <= QB - 8)) begin
                for (int k = int'(m_skip); k < 8; k++) exp_q.push_back(mem_byte(m_faddr + 64'(k)));
                m_skip  = 3'd0;
                m_faddr = m_faddr + 64'd8;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string ctx);
        int n;
        logic [0:119] ew;
        n = exp_q.size();
        check_eq({ctx, ":occupancy"}, 128'(occupancy), 128'(n));
        check_eq({ctx, ":buf_valid"}, 128'(buf_valid), 128'(n >= 15));
        check_eq({ctx, ":fill_ready"}, 128'(fill_ready), 128'(n <= QB - 8));
        check_eq({ctx, ":fetch_addr"}, 128'(fetch_addr), 128'(m_faddr));
        check_eq({ctx, ":decode_pc"}, 128'(decode_pc), 128'(m_dpc));
        check_eq({ctx, ":err"}, 128'(err), 128'(m_err));
        if (n >= 15) begin
            ew = '0;
            for (int i = 0; i < 15; i++) ew[i*8 +: 8] = exp_q[i];
            check_eq({ctx, ":buffer"}, 128'(buffer), 128'(ew));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        redirect    = 1'b0;
        redirect_pc = '0;
        fill_valid  = 1'b0;
        fill_data   = '0;
        consume     = 1'b0;
        byte_incr   = 4'd0;
    endtask

    // Called just after a posedge: drive one cycle, let the edge happen, check.
    task automatic step(input string ctx, input logic rd, input logic [63:0] rpc,
                        input logic fv, input logic cs, input logic [3:0] inc);
        logic [63:0] beat;
        for (int k = 0; k < 8; k++) beat[k*8 +: 8] = mem_byte(m_faddr + 64'(k));
        redirect    = rd;
        redirect_pc = rpc;
        fill_valid  = fv;
        fill_data   = beat;
        consume     = cs;
        byte_incr   = inc;
        @(posedge clk);
        model_step(rd, rpc, fv, cs, inc);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        reset = 1'b1;
        drive_idle();
        model_reset();
        #1;
        check_all(ctx);
        check_eq({ctx, ":buffer_zero"}, 128'(buffer), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic        s_rd;
    logic        s_fv;
    logic        s_cs;
    logic [3:0]  s_inc;
    logic [63:0] s_pc;

    initial begin
        reset = 1'b1;
        drive_idle();
        model_reset();
        #2;
        check_all("reset");
        check_eq("reset:buffer_zero", 128'(buffer), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two aligned beats from 0x0, then a 3-byte consume.
        step("fill0", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("fill1", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        check_eq("fill1:byte14", 128'(buffer[14*8 +: 8]), 128'(8'h0E));
        step("cons3", 1'b0, 64'h0, 1'b0, 1'b1, 4'd3);
        check_eq("cons3:byte0", 128'(buffer[0 +: 8]), 128'(8'h03));

        // Misaligned redirect: first beat contributes 3 bytes.
        step("redir1005", 1'b1, 64'h1005, 1'b0, 1'b0, 4'd0);
        repeat (3) step("fill1005", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);

        // Fill to full, hold a beat while not ready, free space with a consume of 8.
        step("redir2000", 1'b1, 64'h2000, 1'b0, 1'b0, 4'd0);
        repeat (6) step("fill_full", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("full_cons8", 1'b0, 64'h0, 1'b1, 1'b1, 4'd8);
        step("full_held", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);

        // Simultaneous fill and consume at count 20.
        step("redir3004", 1'b1, 64'h3004, 1'b0, 1'b0, 4'd0);
        repeat (3) step("fill3004", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("fill_cons5", 1'b0, 64'h0, 1'b1, 1'b1, 4'd5);

        // Address wrap through 2^64.
        step("redir_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0, 4'd0);
        repeat (3) step("fill_wrap", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("cons_wrap", 1'b0, 64'h0, 1'b0, 1'b1, 4'd10);

        // Redirect wins over same-cycle fill and consume; no err.
        step("redir_cons", 1'b1, 64'h5000, 1'b1, 1'b1, 4'd4);

        // Consume at count 10 is illegal and sticky.
        step("redir4006", 1'b1, 64'h4006, 1'b0, 1'b0, 4'd0);
        repeat (2) step("fill4006", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("cons_short", 1'b0, 64'h0, 1'b0, 1'b1, 4'd4);
        step("err_sticky", 1'b0, 64'h0, 1'b0, 1'b0, 4'd0);
        step("err_redir", 1'b1, 64'h6000, 1'b0, 1'b0, 4'd0);

        // byte_incr of zero is illegal even with a valid window.
        do_reset("rst_a");
        repeat (2) step("fill_z", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("cons_zero", 1'b0, 64'h0, 1'b0, 1'b1, 4'd0);
        do_reset("rst_b");

        // Randomized traffic.
        for (int c = 0; c < 900; c++) begin
            if (c % 300 == 299) do_reset("rst_rand");
            s_rd = ($urandom_range(0, 39) == 0);
            s_pc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) s_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            s_fv = ($urandom_range(0, 9) < 7);
            if (exp_q.size() >= 15) s_cs = ($urandom_range(0, 1) == 1);
            else                    s_cs = ($urandom_range(0, 99) == 0);
            s_inc = ($urandom_range(0, 199) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step("rand", s_rd, s_pc, s_fv, s_cs, s_inc);
        end

        // Asynchronous reset in the middle of an active cycle.
        step("pre_rst", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        step("pre_rst", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);
        fill_valid = 1'b1;
        consume    = 1'b1;
        byte_incr  = 4'd5;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check_eq("async_rst:buffer_zero", 128'(buffer), 128'(0));
        drive_idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_rst", 1'b0, 64'h0, 1'b1, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
